// File: rtl/jk_excitation_driver_if.sv
// Target-word handshake between a sequencing controller and jk_excitation_driver.
interface jk_excitation_driver_if #(
  parameter int WIDTH = 8
);
  logic             tgt_valid;
  logic [WIDTH-1:0] tgt_data;
  logic             tgt_ready;

  modport master (output tgt_valid, output tgt_data, input tgt_ready);
  modport slave  (input tgt_valid, input tgt_data, output tgt_ready);
endinterface

// File: rtl/jk_excitation_driver.sv
// Converts desired JK-bank states into one-cycle J/K excitation pulses and
// checks the bank's q feedback against a mirrored expected state.
module jk_excitation_driver #(
  parameter int WIDTH       = 8,
  parameter int LAT         = 2,
  parameter bit TOGGLE_PREF = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  jk_excitation_driver_if.slave   tgt_bus,
  output logic [WIDTH-1:0]        j,
  output logic [WIDTH-1:0]        k,
  input  logic [WIDTH-1:0]        q_fb,
  output logic                    busy,
  output logic                    err,
  output logic [WIDTH-1:0]        err_bits,
  input  logic                    err_clr
);

  localparam int CNT_W = (LAT < 1) ? 1 : $clog2(LAT + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRIVE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] CHECK = 2'd3;

  logic [1:0]       state;
  logic [WIDTH-1:0] mirror;
  logic [WIDTH-1:0] tgt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] diff;

  // Returns {j, k}; unchanged bits always hold (j=k=0).
  function automatic logic [2*WIDTH-1:0] excite(input logic [WIDTH-1:0] m,
                                                 input logic [WIDTH-1:0] t);
    logic [WIDTH-1:0] jx;
    logic [WIDTH-1:0] kx;
    if (TOGGLE_PREF) begin
      jx = t ^ m;
      kx = t ^ m;
    end else begin
      jx = t & ~m;
      kx = m & ~t;
    end
    return {jx, kx};
  endfunction

  assign tgt_bus.tgt_ready = (state == IDLE);
  assign busy              = (state != IDLE);
  assign diff              = q_fb ^ mirror;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      mirror <= '0;
      tgt    <= '0;
      cnt    <= '0;
      j      <= '0;
      k      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (tgt_bus.tgt_valid) begin
            {j, k} <= excite(mirror, tgt_bus.tgt_data);
            tgt    <= tgt_bus.tgt_data;
            state  <= DRIVE;
          end
        end
        DRIVE: begin
          // The bank samples j/k on this edge, so the mirror advances with it.
          mirror <= tgt;
          j      <= '0;
          k      <= '0;
          cnt    <= CNT_W'(LAT - 1);
          state  <= (LAT == 1) ? CHECK : WAIT;
        end
        WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= CHECK;
        end
        CHECK: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A fresh mismatch takes priority over a coincident clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err      <= 1'b0;
      err_bits <= '0;
    end else if ((state == CHECK) && (diff != '0)) begin
      err      <= 1'b1;
      err_bits <= err_clr ? diff : (err_bits | diff);
    end else if (err_clr) begin
      err      <= 1'b0;
      err_bits <= '0;
    end
  end

endmodule
